fft_chan_sched: RTL and testbench

Frame-level scheduler that shares one `fft_wrapper` instance between `NUM_CH` windowed-sample requesters (e.g. stereo channels). It arbitrates whole frames round-robin, pulses `fft_go`, steers the granted AXI-Stream into the FFT input port, and holds a channel tag valid until the FFT reports idle. Downstream logic uses the tag to label each output spectrum. It sits between the per-channel window blocks and `fft_wrapper`.

---
 rtl/fft_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/fft_chan_sched.sv | 149 ++++++++++++++
 tb/tb_fft_chan_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and stream widths for the FFT channel scheduler.
// The stream widths match the FFT wrapper's input port.
package fft_sched_pkg;

  localparam int IN_AXI_WIDTH  = 32;
  localparam int IN_BYTE_COUNT = IN_AXI_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_GO        = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_DONE = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester after i_last_grant, circularly; one-hot out.
// Purely combinational (0 cycles); the caller registers the result.
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_last_grant,
  output logic [NUM_CH-1:0]         o_gnt
);

  localparam int CW = $clog2(NUM_CH);

  logic [CW-1:0] w_idx;

  // Walk from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    o_gnt = '0;
    w_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CW'((int'(i_last_grant) + k) % NUM_CH);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_chan_sched.sv
// Shares one FFT between NUM_CH requesters: round-robin per frame, go pulse, 0-cycle LOAD mux
// with ready passed only to the granted channel. Optional watchdog: FFT_SCHED_WATCHDOG_EN.
module fft_chan_sched
  import fft_sched_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int FFT_SIZE       = 4096,
  parameter int FRAME_BEATS    = FFT_SIZE,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH*IN_AXI_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_CH*IN_BYTE_COUNT-1:0]   s_axis_tkeep,
  input  logic [NUM_CH-1:0]                 s_axis_tvalid,
  input  logic [NUM_CH-1:0]                 s_axis_tlast,
  output logic [NUM_CH-1:0]                 s_axis_tready,
  output logic [IN_AXI_WIDTH-1:0]           axis_win2fft_tdata,
  output logic [IN_BYTE_COUNT-1:0]          axis_win2fft_tkeep,
  output logic                              axis_win2fft_tvalid,
  output logic                              axis_win2fft_tlast,
  input  logic                              axis_win2fft_tready,
  output logic                              fft_go,
  input  logic                              fft_busy,
  output logic [$clog2(NUM_CH)-1:0]         cur_chan,
  output logic                              chan_valid,
  output logic                              sched_busy,
  input  logic                              err_clr,
  output logic                              err_len,
  output logic                              err_timeout
);

  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(FRAME_BEATS + 1);

  if (NUM_CH < 2 || NUM_CH > 8 || FRAME_BEATS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fft_chan_sched: NUM_CH must be 2..8, FRAME_BEATS and TIMEOUT_CYCLES >= 1");
  end

  sched_state_t      r_state, w_state_nxt;
  logic [CW-1:0]     r_cur_chan, r_last_grant, w_gnt_idx;
  logic [NUM_CH-1:0] w_gnt;
  logic [BW-1:0]     r_beat;
  logic              r_busy_seen, r_err_len;
  logic              w_hs, w_last_beat, w_in_tlast, w_in_tvalid, w_len_set, w_wd_hit;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req        (s_axis_tvalid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt[k]) w_gnt_idx = CW'(k);
    end
  end

  assign w_in_tvalid = s_axis_tvalid[r_cur_chan];
  assign w_in_tlast  = s_axis_tlast[r_cur_chan];
  assign w_last_beat = (r_beat == BW'(FRAME_BEATS - 1));
  assign w_hs        = (r_state == ST_LOAD) && w_in_tvalid && axis_win2fft_tready;
  // Early tlast and missing tlast on the final beat are both length errors.
  assign w_len_set   = w_hs && (w_in_tlast != w_last_beat);

  always_comb begin
    w_state_nxt         = r_state;
    s_axis_tready       = '0;
    axis_win2fft_tdata  = '0;
    axis_win2fft_tkeep  = '0;
    axis_win2fft_tvalid = 1'b0;
    axis_win2fft_tlast  = 1'b0;
    case (r_state)
      ST_IDLE:      if (|s_axis_tvalid && !fft_busy) w_state_nxt = ST_ARB;
      ST_ARB:       w_state_nxt = (|w_gnt) ? ST_GO : ST_IDLE;
      ST_GO:        w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        axis_win2fft_tdata        = s_axis_tdata[r_cur_chan*IN_AXI_WIDTH +: IN_AXI_WIDTH];
        axis_win2fft_tkeep        = s_axis_tkeep[r_cur_chan*IN_BYTE_COUNT +: IN_BYTE_COUNT];
        axis_win2fft_tvalid       = w_in_tvalid;
        axis_win2fft_tlast        = w_in_tlast | w_last_beat;
        s_axis_tready[r_cur_chan] = axis_win2fft_tready;
        if (w_hs && (w_in_tlast || w_last_beat)) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (r_busy_seen && !fft_busy) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
    if (w_wd_hit) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cur_chan   <= '0;
      r_last_grant <= CW'(NUM_CH - 1);
      r_beat       <= '0;
      r_busy_seen  <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ARB && |w_gnt) begin
        r_cur_chan   <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
      end
      if (r_state == ST_ARB) begin
        r_beat      <= '0;
        r_busy_seen <= 1'b0;
      end else begin
        if (w_hs) r_beat <= r_beat + 1'b1;
        if ((r_state == ST_LOAD || r_state == ST_WAIT_DONE) && fft_busy) r_busy_seen <= 1'b1;
      end
      if (w_len_set)    r_err_len <= 1'b1;
      else if (err_clr) r_err_len <= 1'b0;
    end
  end

`ifdef FFT_SCHED_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_err_to;

  assign w_wd_hit = (r_state == ST_LOAD || r_state == ST_WAIT_DONE) &&
                    (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_err_to <= 1'b0;
    end else begin
      if (w_state_nxt != r_state || w_hs)                     r_wd_cnt <= '0;
      else if (r_state == ST_LOAD || r_state == ST_WAIT_DONE) r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_wd_hit)     r_err_to <= 1'b1;
      else if (err_clr) r_err_to <= 1'b0;
    end
  end

  assign err_timeout = r_err_to;
`else
  assign w_wd_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign fft_go     = (r_state == ST_GO);
  assign chan_valid = (r_state == ST_GO) || (r_state == ST_LOAD) || (r_state == ST_WAIT_DONE);
  assign sched_busy = (r_state != ST_IDLE);
  assign cur_chan   = r_cur_chan;
  assign err_len    = r_err_len;

endmodule

// File: tb/tb_fft_chan_sched.sv
// Directed bench for fft_chan_sched: 2 channels, 4096-beat frames, watchdog limit 16 cycles.
// The watchdog scenario follows FFT_SCHED_WATCHDOG_EN.
module tb_fft_chan_sched;
  import fft_sched_pkg::*;

  localparam int NCH = 2;
  localparam int FB  = 4096;
  localparam int W   = IN_AXI_WIDTH;
  localparam int BC  = IN_BYTE_COUNT;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH*W-1:0]  s_axis_tdata = '0;
  logic [NCH*BC-1:0] s_axis_tkeep = '0;
  logic [NCH-1:0]    s_axis_tvalid = '0;
  logic [NCH-1:0]    s_axis_tlast = '0;
  logic [NCH-1:0]    s_axis_tready;
  logic [W-1:0]      axis_win2fft_tdata;
  logic [BC-1:0]     axis_win2fft_tkeep;
  logic              axis_win2fft_tvalid, axis_win2fft_tlast;
  logic              axis_win2fft_tready = 1'b1;
  logic              fft_go;
  logic              fft_busy = 1'b0;
  logic [0:0]        cur_chan;
  logic              chan_valid, sched_busy;
  logic              err_clr = 1'b0;
  logic              err_len, err_timeout;

  int n_checks = 0;
  int n_err = 0;
  int stream_bad = 0;
  int last_seen = 0;
  int go_cnt = 0;

  fft_chan_sched #(.NUM_CH(NCH), .FFT_SIZE(FB), .FRAME_BEATS(FB), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .axis_win2fft_tdata(axis_win2fft_tdata), .axis_win2fft_tkeep(axis_win2fft_tkeep),
    .axis_win2fft_tvalid(axis_win2fft_tvalid), .axis_win2fft_tlast(axis_win2fft_tlast),
    .axis_win2fft_tready(axis_win2fft_tready),
    .fft_go(fft_go), .fft_busy(fft_busy), .cur_chan(cur_chan), .chan_valid(chan_valid),
    .sched_busy(sched_busy), .err_clr(err_clr), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fft_go === 1'b1) go_cnt++;

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    fft_busy = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_go(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (fft_go === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Streams beats 1..nbeats of channel ch starting in LOAD; mismatches accumulate in stream_bad.
  task automatic load_frame(input int ch, input int tlast_at, input int nbeats, input int stall_at);
    logic [W-1:0]   ed;
    logic [BC-1:0]  ek;
    logic [NCH-1:0] er;
    logic           el;
    for (int i = 1; i <= nbeats; i++) begin
      if (i == stall_at) begin
        s_axis_tvalid[ch] = 1'b0;
        repeat (3) begin
          #1;
          if (axis_win2fft_tvalid !== 1'b0 || chan_valid !== 1'b1 || cur_chan !== 1'(ch)) stream_bad++;
          tick();
        end
      end
      ed = W'((ch << 24) | i);
      ek = BC'(i);
      er = NCH'(1) << ch;
      el = (i == tlast_at) || (i == FB);
      s_axis_tdata[ch*W +: W]   = ed;
      s_axis_tkeep[ch*BC +: BC] = ek;
      s_axis_tlast[ch]          = (i == tlast_at);
      s_axis_tvalid[ch]         = 1'b1;
      #1;
      if (s_axis_tready !== er) stream_bad++;
      if (axis_win2fft_tvalid !== 1'b1 || axis_win2fft_tdata !== ed ||
          axis_win2fft_tkeep !== ek || axis_win2fft_tlast !== el) stream_bad++;
      if (axis_win2fft_tlast === 1'b1 && last_seen == 0) last_seen = i;
      tick();
    end
    s_axis_tlast[ch] = 1'b0;
  endtask

  task automatic finish_fft();
    fft_busy = 1'b1;
    repeat (3) tick();
    fft_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({fft_go, chan_valid, sched_busy, cur_chan, err_len, err_timeout} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 000000", {fft_go, chan_valid, sched_busy, cur_chan, err_len, err_timeout});
    end
    n_checks++;
    if ({s_axis_tready, axis_win2fft_tvalid, axis_win2fft_tlast, axis_win2fft_tdata, axis_win2fft_tkeep} !== '0) begin
      n_err++;
      $display("FAIL reset_stream: got tready=%b tvalid=%b tdata=%h required all 0", s_axis_tready, axis_win2fft_tvalid, axis_win2fft_tdata);
    end
    do_reset();
  endtask

  task automatic test_single();
    int cyc, go0;
    do_reset();
    go0 = go_cnt;
    s_axis_tvalid[0] = 1'b1;
    wait_go(cyc);
    n_checks++;
    if (cyc != 2) begin n_err++; $display("FAIL single_go_latency: got %0d required 2", cyc); end
    n_checks++;
    if (cur_chan !== 1'b0 || chan_valid !== 1'b1 || s_axis_tready !== 2'b00) begin
      n_err++;
      $display("FAIL single_grant: got chan=%0d valid=%b tready=%b required 0 1 00", cur_chan, chan_valid, s_axis_tready);
    end
    tick();
    stream_bad = 0;
    load_frame(0, FB, FB, 0);
    s_axis_tvalid = '0;
    n_checks++;
    if (stream_bad != 0) begin n_err++; $display("FAIL single_stream: got %0d bad beats required 0", stream_bad); end
    n_checks++;
    if (err_len !== 1'b0 || chan_valid !== 1'b1 || sched_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_wait: got err_len=%b chan_valid=%b busy=%b required 0 1 1", err_len, chan_valid, sched_busy);
    end
    finish_fft();
    n_checks++;
    if (sched_busy !== 1'b0 || chan_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b chan_valid=%b required 0 0", sched_busy, chan_valid);
    end
    n_checks++;
    if (go_cnt - go0 != 1) begin n_err++; $display("FAIL single_go_count: got %0d required 1", go_cnt - go0); end
  endtask

  task automatic test_round_robin();
    int cyc, exp;
    do_reset();
    s_axis_tvalid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp = f % 2;
      wait_go(cyc);
      n_checks++;
      if (cyc != 2 || cur_chan !== 1'(exp)) begin
        n_err++;
        $display("FAIL rr_grant_%0d: got chan=%0d after %0d cycles required chan=%0d after 2", f, cur_chan, cyc, exp);
      end
      tick();
      stream_bad = 0;
      load_frame(exp, FB, FB, 0);
      n_checks++;
      if (stream_bad != 0) begin n_err++; $display("FAIL rr_stream_%0d: got %0d bad beats required 0", f, stream_bad); end
      finish_fft();
    end
    s_axis_tvalid = '0;
  endtask

  task automatic test_len_error();
    int cyc;
    do_reset();
    s_axis_tvalid[1] = 1'b1;
    wait_go(cyc);
    n_checks++;
    if (cur_chan !== 1'b1) begin n_err++; $display("FAIL len_grant: got %0d required 1", cur_chan); end
    tick();
    stream_bad = 0;
    load_frame(1, 100, 100, 50);
    n_checks++;
    if (stream_bad != 0) begin n_err++; $display("FAIL len_stream_stall: got %0d bad beats required 0", stream_bad); end
    n_checks++;
    if (err_len !== 1'b1) begin n_err++; $display("FAIL len_err_set: got %b required 1", err_len); end
    #1;
    n_checks++;
    if (s_axis_tready !== 2'b00 || chan_valid !== 1'b1) begin
      n_err++;
      $display("FAIL len_wait_done: got tready=%b chan_valid=%b required 00 1", s_axis_tready, chan_valid);
    end
    s_axis_tvalid = '0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_len !== 1'b0) begin n_err++; $display("FAIL len_err_clr: got %b required 0", err_len); end
    finish_fft();
  endtask

  task automatic test_no_tlast();
    int cyc;
    do_reset();
    s_axis_tvalid[0] = 1'b1;
    wait_go(cyc);
    tick();
    err_clr = 1'b1;
    stream_bad = 0;
    last_seen = 0;
    load_frame(0, 0, FB, 0);
    err_clr = 1'b0;
    n_checks++;
    if (err_len !== 1'b1) begin n_err++; $display("FAIL notlast_err_over_clr: got %b required 1", err_len); end
    n_checks++;
    if (last_seen != FB) begin n_err++; $display("FAIL notlast_forced_beat: got %0d required %0d", last_seen, FB); end
    n_checks++;
    if (stream_bad != 0) begin n_err++; $display("FAIL notlast_stream: got %0d bad beats required 0", stream_bad); end
    s_axis_tdata[W-1:0] = W'(FB + 1);
    #1;
    n_checks++;
    if (s_axis_tready !== 2'b00 || axis_win2fft_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL notlast_beat4097_stall: got tready=%b tvalid=%b required 00 0", s_axis_tready, axis_win2fft_tvalid);
    end
    tick();
    n_checks++;
    if (err_len !== 1'b1) begin n_err++; $display("FAIL notlast_err_sticky: got %b required 1", err_len); end
    s_axis_tvalid = '0;
    finish_fft();
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    do_reset();
    s_axis_tvalid[0] = 1'b1;
    wait_go(cyc);
    tick();
    load_frame(0, 0, 1999, 0);
    s_axis_tdata[W-1:0] = W'(2000);
    s_axis_tvalid[0] = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 2'b01) begin n_err++; $display("FAIL rst_pre_load: got tready=%b required 01", s_axis_tready); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({fft_go, chan_valid, sched_busy, cur_chan, s_axis_tready, axis_win2fft_tvalid, axis_win2fft_tlast} !== 8'b0 ||
        axis_win2fft_tdata !== '0) begin
      n_err++;
      $display("FAIL rst_mid_load: got go=%b cv=%b busy=%b ch=%0d rdy=%b tv=%b td=%h required all 0",
               fft_go, chan_valid, sched_busy, cur_chan, s_axis_tready, axis_win2fft_tvalid, axis_win2fft_tdata);
    end
    tick();
    reset = 1'b1;
    s_axis_tvalid = 2'b11;
    wait_go(cyc);
    n_checks++;
    if (cyc != 2 || cur_chan !== 1'b0) begin
      n_err++;
      $display("FAIL rst_next_grant: got chan=%0d after %0d cycles required chan=0 after 2", cur_chan, cyc);
    end
    do_reset();
  endtask

  task automatic test_busy_hold();
    int cyc, go0;
    do_reset();
    go0 = go_cnt;
    fft_busy = 1'b1;
    s_axis_tvalid[0] = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (sched_busy !== 1'b0 || go_cnt != go0) begin
      n_err++;
      $display("FAIL busy_hold_idle: got busy=%b gos=%0d required 0 0", sched_busy, go_cnt - go0);
    end
    fft_busy = 1'b0;
    wait_go(cyc);
    n_checks++;
    if (cyc != 2) begin n_err++; $display("FAIL busy_release_go: got %0d required 2", cyc); end
    do_reset();
  endtask

  task automatic test_watchdog();
    int cyc;
    do_reset();
    s_axis_tvalid[0] = 1'b1;
    wait_go(cyc);
    tick();
    load_frame(0, FB, FB, 0);
    s_axis_tvalid = '0;
    fft_busy = 1'b1;
`ifdef FFT_SCHED_WATCHDOG_EN
    cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (err_timeout === 1'b1) begin
        cyc = n;
        break;
      end
    end
    n_checks++;
    if (cyc != 16) begin n_err++; $display("FAIL wd_cycles: got %0d required 16", cyc); end
    n_checks++;
    if (sched_busy !== 1'b0 || chan_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wd_idle: got busy=%b chan_valid=%b required 0 0", sched_busy, chan_valid);
    end
    fft_busy = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL wd_clr: got %b required 0", err_timeout); end
`else
    repeat (40) tick();
    n_checks++;
    if (err_timeout !== 1'b0 || sched_busy !== 1'b1 || chan_valid !== 1'b1) begin
      n_err++;
      $display("FAIL nowd_wait: got err_to=%b busy=%b chan_valid=%b required 0 1 1", err_timeout, sched_busy, chan_valid);
    end
    fft_busy = 1'b0;
    tick();
    n_checks++;
    if (sched_busy !== 1'b0) begin n_err++; $display("FAIL nowd_release: got busy=%b required 0", sched_busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_error();
    test_no_tlast();
    test_reset_mid_load();
    test_busy_hold();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
